vc_fifo_scheduler: RTL and testbench

//  Round-robin scheduler that drains NUM_VC per-virtual-channel 10-bit transaction FIFOs into one shared

---
 rtl/vc_fifo_scheduler_if.sv | 22 ++
 rtl/vc_fifo_scheduler.sv | 139 +++++++++++++
 tb/tb_vc_fifo_scheduler.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_fifo_scheduler_if.sv
// Handshake bundle between the VC scheduler, its source FIFOs and the egress FIFO.
interface vc_fifo_scheduler_if #(
  parameter int NUM_VC = 4,
  parameter int DATA_W = 10
);
  logic [NUM_VC-1:0]        vc_empty;
  logic [NUM_VC-1:0]        vc_pop;
  logic [NUM_VC*DATA_W-1:0] vc_data;
  logic                     egr_almost_full;
  logic                     egr_push;
  logic [DATA_W-1:0]        egr_data;

  modport master (
    input  vc_empty, vc_data, egr_almost_full,
    output vc_pop, egr_push, egr_data
  );

  modport slave (
    output vc_empty, vc_data, egr_almost_full,
    input  vc_pop, egr_push, egr_data
  );
endinterface

// File: rtl/vc_fifo_scheduler.sv
// Round-robin drain of NUM_VC source FIFOs into one egress FIFO with bounded bursts.
// Optional WORD_COUNT_EN builds per-VC 16-bit transferred-word counters.
module vc_fifo_scheduler #(
  parameter int NUM_VC    = 4,
  parameter int DATA_W    = 10,
  parameter int BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  vc_fifo_scheduler_if.master bus,
  output logic [1:0]          grant_vc,
  output logic                busy,
  input  logic [1:0]          cnt_sel,
  output logic [15:0]         cnt_out
);

  typedef enum logic [1:0] {INIT, IDLE, ACTIVE, STALL} state_t;

  state_t            state, state_nxt;
  logic [1:0]        grant_nxt;
  logic [3:0]        burst, burst_nxt;
  logic              do_pop;
  logic [1:0]        sel_vc;
  logic [3:0]        base_cnt, new_cnt;
  logic [2:0]        after_grant, after_sel;
  logic [NUM_VC-1:0] pop;
  logic              s1_valid;
  logic [1:0]        s1_vc;

  // {found, index} of the first non-empty VC after 'from', wrapping back to 'from' itself last.
  function automatic logic [2:0] pick_after(input logic [1:0] from, input logic [NUM_VC-1:0] empty);
    logic [2:0] r;
    logic [1:0] idx;
    r = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = from + 2'(k);
      if (!r[2] && !empty[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_vc;
    burst_nxt   = burst;
    do_pop      = 1'b0;
    sel_vc      = grant_vc;
    base_cnt    = '0;
    new_cnt     = '0;
    pop         = '0;
    after_sel   = '0;
    after_grant = pick_after(grant_vc, bus.vc_empty);
    case (state)
      INIT: state_nxt = IDLE;
      IDLE: begin
        if (enable && after_grant[2] && !bus.egr_almost_full) begin
          state_nxt = ACTIVE;
          do_pop    = 1'b1;
          sel_vc    = after_grant[1:0];
        end
      end
      ACTIVE: begin
        if (!enable || !after_grant[2]) begin
          state_nxt = IDLE;
          burst_nxt = '0;
        end else if (bus.egr_almost_full) begin
          state_nxt = STALL;
        end else begin
          // An emptied grant hands over in the same cycle, so no bubble appears.
          do_pop = 1'b1;
          if (!bus.vc_empty[grant_vc]) base_cnt = burst;
          else                         sel_vc   = after_grant[1:0];
        end
      end
      STALL: if (!bus.egr_almost_full) state_nxt = ACTIVE;
      default: state_nxt = INIT;
    endcase

    if (do_pop) begin
      pop[sel_vc] = 1'b1;
      new_cnt     = base_cnt + 4'd1;
      after_sel   = pick_after(sel_vc, bus.vc_empty);
      if (new_cnt == 4'(BURST_MAX) && after_sel[2]) begin
        grant_nxt = after_sel[1:0];
        burst_nxt = '0;
      end else begin
        grant_nxt = sel_vc;
        burst_nxt = new_cnt;
      end
    end
  end

  assign bus.vc_pop = pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= INIT;
      grant_vc     <= '0;
      burst        <= '0;
      s1_valid     <= 1'b0;
      s1_vc        <= '0;
      bus.egr_push <= 1'b0;
      bus.egr_data <= '0;
    end else begin
      state        <= state_nxt;
      grant_vc     <= grant_nxt;
      burst        <= burst_nxt;
      s1_valid     <= do_pop;
      s1_vc        <= sel_vc;
      bus.egr_push <= s1_valid;
      if (s1_valid) bus.egr_data <= bus.vc_data[s1_vc*DATA_W +: DATA_W];
    end
  end

  assign busy = s1_valid | bus.egr_push | (state == ACTIVE) | (state == STALL);

`ifdef WORD_COUNT_EN
  logic [1:0]  egr_vc;
  logic [15:0] cnt [NUM_VC];

  always_ff @(posedge clk) begin
    if (!reset) begin
      egr_vc <= '0;
      for (int unsigned i = 0; i < NUM_VC; i++) cnt[i] <= '0;
    end else begin
      if (s1_valid)     egr_vc      <= s1_vc;
      if (bus.egr_push) cnt[egr_vc] <= cnt[egr_vc] + 16'd1;
    end
  end

  assign cnt_out = cnt[cnt_sel];
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_out        = 16'h0000;
`endif

endmodule

// File: tb/tb_vc_fifo_scheduler.sv
// Self-checking bench: queue-based source FIFO model plus a pop->push latency scoreboard.
module tb_vc_fifo_scheduler;
  localparam int NUM_VC    = 4;
  localparam int DATA_W    = 10;
  localparam int BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [1:0]  grant_vc, cnt_sel;
  logic        busy;
  logic [15:0] cnt_out;

  always #5 clk = ~clk;

  vc_fifo_scheduler_if #(.NUM_VC(NUM_VC), .DATA_W(DATA_W)) bus ();

  vc_fifo_scheduler #(.NUM_VC(NUM_VC), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .bus      (bus),
    .grant_vc (grant_vc),
    .busy     (busy),
    .cnt_sel  (cnt_sel),
    .cnt_out  (cnt_out)
  );

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] q [NUM_VC][$];
  logic [DATA_W-1:0] out_log[$];
  logic              exp_v1 = 1'b0, exp_v2 = 1'b0;
  logic [DATA_W-1:0] exp_d1 = '0, exp_d2 = '0, hold_d = '0;
  logic [NUM_VC-1:0] last_pop;
  logic              last_busy;
  logic              armed = 1'b0;
  int                prev_vc = -1;
  int                run = 0;
  int                exp_seq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NUM_VC; i++) if (q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // One clock cycle: present flags, check outputs, advance the source and pipeline model.
  task automatic tick();
    logic [NUM_VC-1:0] p;
    logic [DATA_W-1:0] w, exp_data;
    logic              r;
    int                v;
    bit                others;
    for (int i = 0; i < NUM_VC; i++) bus.vc_empty[i] = (q[i].size() == 0);
    #1;
    p = bus.vc_pop;
    r = reset;
    v = -1;
    w = '0;
    for (int i = 0; i < NUM_VC; i++) if (p[i]) v = i;
    if (v >= 0 && q[v].size() != 0) w = q[v][0];
    exp_data = exp_v2 ? exp_d2 : hold_d;
    if (armed) begin
      chk("pop_onehot", 32'($countones(p) <= 1), 1);
      chk("pop_of_empty", 32'(p & bus.vc_empty), 0);
      chk("egr_push", 32'(bus.egr_push), 32'(exp_v2));
      chk("egr_data", 32'(bus.egr_data), 32'(exp_data));
      if (bus.egr_push) out_log.push_back(bus.egr_data);
      if (v >= 0) begin
        others = 1'b0;
        for (int i = 0; i < NUM_VC; i++) if (i != v && q[i].size() != 0) others = 1'b1;
        if (!others)           run = 0;
        else if (v == prev_vc) run++;
        else                   run = 1;
        prev_vc = v;
        chk("burst_len", 32'(run <= BURST_MAX), 1);
      end
    end
    hold_d    = exp_data;
    last_pop  = p;
    last_busy = busy;
    @(posedge clk);
    if (!r) begin
      armed   = 1'b1;
      exp_v1  = 1'b0;
      exp_v2  = 1'b0;
      hold_d  = '0;
      prev_vc = -1;
      run     = 0;
    end else begin
      exp_v2 = exp_v1;
      exp_d2 = exp_d1;
      exp_v1 = (v >= 0);
      exp_d1 = w;
    end
    #1;
    if (v >= 0 && q[v].size() != 0) begin
      void'(q[v].pop_front());
      bus.vc_data[v*DATA_W +: DATA_W] = w;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((!all_empty() || exp_v1 || exp_v2) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(all_empty() && !exp_v1 && !exp_v2), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rem[NUM_VC];
    int g, total, n, k, first_idx;
    int pushes_before;

    reset = 1'b0;
    enable = 1'b1;
    cnt_sel = 2'd0;
    bus.egr_almost_full = 1'b0;
    bus.vc_data = '0;
    bus.vc_empty = '1;
    @(negedge clk);

    // Reset with everything empty, then INIT and IDLE.
    do_reset();
    chk("rst_pop", 32'(bus.vc_pop), 0);
    chk("rst_push", 32'(bus.egr_push), 0);
    chk("rst_data", 32'(bus.egr_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_vc), 0);

    // VC0 holds three words; INIT cycle must not pop.
    out_log.delete();
    q[0].push_back(10'h001);
    q[0].push_back(10'h002);
    q[0].push_back(10'h003);
    tick();
    chk("init_nopop", 32'(last_pop), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("vc0_pop", 32'(last_pop), 32'b0001);
    end
    chk("vc0_busy", 32'(last_busy), 1);
    tick();
    chk("vc0_done", 32'(last_pop), 0);
    drain(20);
    chk("vc0_count", 32'(out_log.size()), 3);
    for (int i = 0; i < 3 && i < out_log.size(); i++) chk("vc0_word", 32'(out_log[i]), 32'(i + 1));

    // All VCs loaded with 6 words: bounded round-robin bursts starting at VC1.
    do_reset();
    for (int i = 0; i < NUM_VC; i++)
      for (int j = 0; j < 6; j++) q[i].push_back(10'(i * 16 + j + 1));
    exp_seq.delete();
    total = 0;
    for (int i = 0; i < NUM_VC; i++) begin rem[i] = 6; total += 6; end
    g = 0;
    while (total > 0) begin
      for (k = 1; k <= NUM_VC; k++) if (rem[(g + k) % NUM_VC] > 0) break;
      g = (g + k) % NUM_VC;
      n = (rem[g] < BURST_MAX) ? rem[g] : BURST_MAX;
      for (int j = 0; j < n; j++) exp_seq.push_back(g);
      rem[g] -= n;
      total  -= n;
    end
    tick();
    foreach (exp_seq[i]) begin
      tick();
      chk("rr_order", 32'(last_pop), 32'(1) << exp_seq[i]);
    end
    drain(20);

    // almost_full mid-burst: pops stop at once, only in-flight words reach egress.
    do_reset();
    for (int j = 0; j < 8; j++) q[2].push_back(10'(10'h200 + j));
    for (int j = 0; j < 4; j++) q[3].push_back(10'(10'h300 + j));
    tick();
    tick();
    chk("af_pop_a", 32'(last_pop), 32'b0100);
    tick();
    chk("af_pop_b", 32'(last_pop), 32'b0100);
    pushes_before = out_log.size();
    bus.egr_almost_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("af_nopop", 32'(last_pop), 0);
    end
    chk("af_inflight", 32'(out_log.size() - pushes_before), 2);
    bus.egr_almost_full = 1'b0;
    first_idx = 0;
    tick();
    while (last_pop == 0 && first_idx < 3) begin
      tick();
      first_idx++;
    end
    chk("af_resume", 32'(last_pop), 32'b0100);
    exp_seq = '{2, 3, 3, 3, 3};
    foreach (exp_seq[i]) begin
      tick();
      chk("af_after", 32'(last_pop), 32'(1) << exp_seq[i]);
    end
    drain(40);

    // Reset while two words are in flight: neither may be pushed.
    do_reset();
    for (int j = 0; j < 4; j++) q[1].push_back(10'(10'h100 + j));
    tick();
    tick();
    chk("r5_pop", 32'(last_pop), 32'b0010);
    pushes_before = out_log.size();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("r5_grant", 32'(grant_vc), 0);
    chk("r5_busy", 32'(busy), 0);
    tick();
    tick();
    chk("r5_nopush", 32'(out_log.size() - pushes_before), 0);
    drain(20);

    // Per-VC word counter.
    do_reset();
    for (int j = 0; j < 5; j++) q[2].push_back(10'(10'h050 + j));
    tick();
    drain(20);
    cnt_sel = 2'd2;
    #1;
`ifdef WORD_COUNT_EN
    chk("cnt_vc2", 32'(cnt_out), 5);
    cnt_sel = 2'd0;
    #1;
    chk("cnt_vc0", 32'(cnt_out), 0);
`else
    chk("cnt_off", 32'(cnt_out), 0);
`endif
    @(negedge clk);

    // Randomised traffic with almost_full and enable noise.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int vv;
        vv = int'($urandom_range(0, NUM_VC - 1));
        if (q[vv].size() < 8) q[vv].push_back(10'($urandom));
      end
      bus.egr_almost_full = ($urandom_range(0, 6) == 0);
      enable = ($urandom_range(0, 9) != 0);
      tick();
    end
    bus.egr_almost_full = 1'b0;
    enable = 1'b1;
    drain(300);
    tick();
    tick();
    chk("final_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
